// File: rtl/dht22_pkg.sv
// dht22_pkg: timing, state encoding and checksum shared by the DHT22
// responder and the DHT22 host reader so both ends agree on the bus timing.
package dht22_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HOST_LOW,
        S_WAIT_REL,
        S_RESP_DLY,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_END_LOW
    } dht_state_e;

    localparam int T_RESP_DLY  = 30;
    localparam int T_RESP_LOW  = 80;
    localparam int T_RESP_HIGH = 80;
    localparam int T_BIT_LOW   = 50;
    localparam int T_BIT0_HIGH = 26;
    localparam int T_BIT1_HIGH = 70;
    localparam int T_END_LOW   = 50;

    localparam int FRAME_BITS  = 40;
    localparam int US_W        = 16;

    function automatic logic [7:0] dht_checksum(
        input logic [15:0] hum,
        input logic [15:0] temp
    );
        return hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0];
    endfunction

endpackage

// File: rtl/dht22_us_timer.sv
// dht22_us_timer: divides clk down to a microsecond tick and counts elapsed
// microseconds; a synchronous clear restarts both so durations are exact.
module dht22_us_timer
    import dht22_pkg::*;
#(
    parameter int US_CYCLES = 50
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    output logic            tick,
    output logic [US_W-1:0] us_count
);

    localparam int PW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;

    logic [PW-1:0]   pre_q, pre_d;
    logic [US_W-1:0] us_q, us_d;

    assign tick     = (pre_q == PW'(US_CYCLES - 1));
    assign us_count = us_q;

    // Prescaler wraps each microsecond; the count saturates instead of wrapping.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
        us_d  = us_q;
        if (tick && (us_q != '1)) begin
            us_d = us_q + US_W'(1);
        end
        if (clr) begin
            pre_d = '0;
            us_d  = '0;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            us_q  <= '0;
        end else begin
            pre_q <= pre_d;
            us_q  <= us_d;
        end
    end

endmodule

// File: rtl/dht22_responder.sv
// dht22_responder: sensor side of the DHT22 single-wire bus. Qualifies the
// host start pulse and answers with the preamble and a 40-bit data frame.
module dht22_responder
    import dht22_pkg::*;
#(
    parameter int US_CYCLES    = 50,
    parameter int START_MIN_US = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dht_in,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    output logic        dht_drive_low,
    output logic        busy,
    output logic        frame_done
);

    logic sync1_q, sync2_q;
    logic din;

    dht_state_e state_q, state_d;
    logic [FRAME_BITS-1:0] sr_q, sr_d;
    logic [5:0]            bit_q, bit_d;
    logic                  busy_q, busy_d;
    logic                  drive_q, drive_d;
    logic                  done_q, done_d;

    logic            tick;
    logic [US_W-1:0] us_count;
    logic [US_W-1:0] dur;
    logic            expired;
    logic            clr;

    assign din = sync2_q;

    // Bring the asynchronous bus level into the clk domain; idle bus is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= dht_in;
            sync2_q <= sync1_q;
        end
    end

    dht22_us_timer #(
        .US_CYCLES (US_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .tick     (tick),
        .us_count (us_count)
    );

    // Duration of the current state in microseconds.
    always_comb begin
        dur = '1;
        unique case (state_q)
            S_HOST_LOW:  dur = US_W'(START_MIN_US);
            S_RESP_DLY:  dur = US_W'(T_RESP_DLY);
            S_RESP_LOW:  dur = US_W'(T_RESP_LOW);
            S_RESP_HIGH: dur = US_W'(T_RESP_HIGH);
            S_BIT_LOW:   dur = US_W'(T_BIT_LOW);
            S_BIT_HIGH:  dur = sr_q[FRAME_BITS-1] ? US_W'(T_BIT1_HIGH)
                                                 : US_W'(T_BIT0_HIGH);
            S_END_LOW:   dur = US_W'(T_END_LOW);
            default:     dur = '1;
        endcase
    end

    // Last cycle of the state: leaving now makes it last dur*US_CYCLES cycles.
    assign expired = tick && (us_count == dur - US_W'(1));

    // Next-state and next-output logic; the HOST_LOW expiry wins over a
    // release seen in the same cycle so a full-length start is accepted.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!din) state_d = S_HOST_LOW;
            end
            S_HOST_LOW: begin
                if (expired) begin
                    state_d = S_WAIT_REL;
                    sr_d    = {humidity, temperature,
                               dht_checksum(humidity, temperature)};
                    bit_d   = '0;
                    busy_d  = 1'b1;
                end else if (din) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_REL: begin
                if (din) state_d = S_RESP_DLY;
            end
            S_RESP_DLY: begin
                if (expired) state_d = S_RESP_LOW;
            end
            S_RESP_LOW: begin
                if (expired) state_d = S_RESP_HIGH;
            end
            S_RESP_HIGH: begin
                if (expired) state_d = S_BIT_LOW;
            end
            S_BIT_LOW: begin
                if (expired) state_d = S_BIT_HIGH;
            end
            S_BIT_HIGH: begin
                if (expired) begin
                    sr_d    = {sr_q[FRAME_BITS-2:0], 1'b0};
                    bit_d   = bit_q + 6'd1;
                    state_d = (bit_q == 6'(FRAME_BITS - 1)) ? S_END_LOW
                                                            : S_BIT_LOW;
                end
            end
            S_END_LOW: begin
                if (expired) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        drive_d = (state_d == S_RESP_LOW) ||
                  (state_d == S_BIT_LOW)  ||
                  (state_d == S_END_LOW);
        clr     = (state_d != state_q);
    end

    // FSM state and registered outputs; reset releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            drive_q <= drive_d;
            done_q  <= done_d;
        end
    end

    assign dht_drive_low = drive_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;

endmodule

// File: doc/dht22_responder.md
# dht22_responder

Synthesizable emulation of the DHT22 sensor side of the single-wire bus. It detects the host start pulse and answers with the response preamble and a 40-bit frame: humidity, temperature and checksum. It sits on the board opposite the DHT22 host reader, so the sensor path can be exercised in simulation and on FPGA without a physical sensor. The bus is open-drain: the block only ever pulls the line low or releases it.

## Interface
- US_CYCLES, 50, clk cycles per microsecond (50 MHz clock); the bench uses 1.
- START_MIN_US, 1000, minimum host low time accepted as a start request.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dht_in  in  1  sampled bus level, asynchronous to clk.
- humidity  in  16  value to report; latched once per frame.
- temperature  in  16  value to report; latched once per frame.
- dht_drive_low  out  1  1 = pull bus low, 0 = release (pull-up makes it high).
- busy  out  1  high from start qualification until the frame ends.
- frame_done  out  1  single-cycle pulse when a frame completes.

## Operation
- dht_in passes through a 2-FF synchronizer; all decisions use the synchronized value `din`.
- A microsecond tick divides clk by US_CYCLES. The tick counter clears on every state change, so each state duration is exact in cycles.
- FSM states and transitions:
  - IDLE, drive 0:
    - `din` = 0 -> HOST_LOW.
  - HOST_LOW:
    - Counts low microseconds.
    - `din` = 1 before START_MIN_US -> IDLE (glitch; no response, busy stays 0).
    - START_MIN_US reached -> latch `{humidity, temperature, checksum}` into a 40-bit shift register, set busy, go to WAIT_REL.
  - WAIT_REL:
    - `din` = 1 -> RESP_DLY.
    - There is no timeout; the host may hold the line low indefinitely.
  - RESP_DLY: release for 30 us -> RESP_LOW.
  - RESP_LOW: drive low for 80 us -> RESP_HIGH.
  - RESP_HIGH: release for 80 us -> BIT_LOW.
  - BIT_LOW: drive low for 50 us -> BIT_HIGH.
  - BIT_HIGH:
    - Release for 26 us if the current bit is 0, 70 us if it is 1.
    - Then shift left; if 40 bits have been sent -> END_LOW, else -> BIT_LOW.
  - END_LOW: drive low for 50 us -> IDLE, clear busy, pulse frame_done.
- checksum = (hum[15:8] + hum[7:0] + temp[15:8] + temp[7:0]) mod 256; carries are discarded.
- Bit order is MSB first: hum_hi, hum_lo, temp_hi, temp_lo, checksum.
- From RESP_DLY through END_LOW, `din` is ignored.
- Input changes after the latch do not affect the frame in progress.

## Timing
- Reset values: dht_drive_low = 0, busy = 0, frame_done = 0, state = IDLE, synchronizer flops = 1 (idle bus).
- Reset asserted mid-frame releases the bus immediately (asynchronously). After reset deasserts, the block waits for a fresh start pulse.
- Input latency: a `din` edge is seen 2 cycles after the dht_in edge.
- Start qualification: busy rises at the cycle where the HOST_LOW count reaches START_MIN_US × US_CYCLES.
- Release to response: dht_drive_low rises exactly 30 × US_CYCLES cycles after the RESP_DLY entry cycle.
- Frame duration: total frame time after the host release is deterministic, 30 + 80 + 80 + 40×50 + Σ(high times) + 50 us.
- frame_done is asserted on the same cycle dht_drive_low falls to 0 at the end of END_LOW.
- Outputs are registered; dht_drive_low has no combinational path from any input.

## Structure
- Package dht22_pkg holds:
  - state enum;
  - timing constants: T_RESP_DLY=30, T_RESP_LOW=80, T_RESP_HIGH=80, T_BIT_LOW=50, T_BIT0_HIGH=26, T_BIT1_HIGH=70, T_END_LOW=50;
  - FRAME_BITS=40.
- The package is shared with the DHT22 host reader so both ends agree on timing.
- One sub-module, dht22_us_timer: US_CYCLES prescaler plus microsecond counter with synchronous clear. It outputs the elapsed microseconds.

## Test plan
- **Nominal frame:** US_CYCLES=1, hum=0x028C, temp=0x015F; host holds low 1000 us, then releases. The decoded 40 bits must equal 0x028C015FEE, frame_done pulses once, and busy is high for the whole frame.
- **Checksum wrap:** hum=0xFFFF, temp=0xFFFF -> checksum byte 0xFC; the last 8 high pulses read as 70,70,70,70,70,70,26,26 us.
- **Glitch rejection:** host low for 999 us, then release -> dht_drive_low stays 0, busy stays 0, no frame_done.
- **Mid-frame input change:** change hum to 0x1234 during bit 5 -> the frame still carries 0x028C, and the next frame carries 0x1234.
- **Reset mid-frame:** assert reset during BIT_LOW of bit 20 -> dht_drive_low is 0 in the same cycle. After release, a new start pulse yields a complete, correct frame.
- **Long host hold:** host low 5000 us -> the response begins exactly 30 us after release; no early drive.
